matmul_seq_mac: RTL and testbench
=================================

// Module: matmul_seq_mac
// PURPOSE
// - Parametrised N x N unsigned matrix multiplier, R = A x B. Successor to the fixed 3x3 combinational-loop calculator.
// - Uses one shared multiply-accumulate unit, iterated over i,j,k, instead of N^3 parallel multipliers.
// - Has valid/ready handshakes on input and output. Results are held until consumed.
// - Sits between the operand register bank and the result display/readback logic.
// PARAMETERS
// - N      3   matrix dimension (>=2)
// - W      16  element width, for operands and results
// - ACC_W  localparam = 2*W + $clog2(N); accumulator width, cannot overflow internally
// PORTS
// - clk        in   1        rising-edge clock
// - rst_n      in   1        asynchronous, active-low reset
// - in_valid   in   1        a_flat/b_flat hold a valid operand pair
// - in_ready   out  1        block can accept operands
// - a_flat     in   N*N*W    A; element [i][j] at bits [(i*N+j)*W +: W]
// - b_flat     in   N*N*W    B; same packing as a_flat
// - out_valid  out  1        r_flat holds a complete result
// - out_ready  in   1        consumer accepts the result
// - r_flat     out  N*N*W    R; same packing as a_flat
// - busy       out  1        high during COMPUTE
// - sat_flags  out  N*N      per-element saturation flag, bit i*N+j (see CONFIGURATION)
// BEHAVIOUR
// - One clock (clk). Reset is asynchronous and active-low (rst_n).
// - Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, r_flat=0, sat_flags=0, acc=0, i=j=k=0.
// - States: IDLE -> COMPUTE -> DONE -> IDLE.
// - IDLE: in_ready=1.
//   - On in_valid && in_ready at an edge: latch A and B into internal registers; clear i,j,k,acc; go to COMPUTE.
//   - Inputs may change freely after the accept edge.
// - COMPUTE: in_ready=0, busy=1. Each cycle performs one MAC: sum = acc + A[i][k]*B[k][j], in ACC_W bits.
//   - k<N-1: acc<=sum; k<=k+1.
//   - k==N-1: R[i][j] <= reduce(sum); acc<=0; k<=0; advance j, and wrap j into i.
//   - i=j=k=N-1: final write; go to DONE.
// - Latency: out_valid goes high exactly N^3 cycles after the accept edge (27 for N=3).
// - DONE: out_valid=1, busy=0, in_ready=0.
//   - r_flat and sat_flags stay stable until out_valid && out_ready at an edge, then go to IDLE.
//   - r_flat keeps its last value in IDLE.
// - Simultaneous events:
//   - in_valid is ignored in COMPUTE and DONE; no operand is lost, because in_ready is low.
//   - The earliest next accept is the cycle after the output handshake.
// - r_flat is updated element-by-element during COMPUTE. Consumers may sample it only while out_valid=1.
// - Reset mid-operation (any state): the computation is aborted and the reset values apply immediately (async).
//   - No out_valid pulse for the aborted job.
// - Arithmetic: unsigned only. reduce() is set by the macro below.
// CONFIGURATION
// - Macro MATMUL_SATURATE_EN.
// - Defined:
//   - reduce(sum) = (sum > 2^W-1) ? 2^W-1 : sum[W-1:0].
//   - sat_flags[i*N+j] is set when element [i][j] clamps.
//   - sat_flags clears on accept of the next job.
// - Undefined:
//   - reduce(sum) = sum[W-1:0] (modulo 2^W, matching the legacy calculator).
//   - sat_flags is tied to 0.
// TESTING
// - Latency, N=3, W=16: A=identity, B=1..9 row-major, out_ready=1.
//   - Expect: r_flat = B; out_valid exactly 27 cycles after accept; busy high 27 cycles.
// - N=3, all A=2, all B=2.
//   - Expect: every R element = 12, sat_flags = 0.
// - Overflow: all A=16'hFFFF, all B=16'h0002 (true sum 0x5FFFA).
//   - Without MATMUL_SATURATE_EN: every R = 16'hFFFA, sat_flags = 0.
//   - With MATMUL_SATURATE_EN: every R = 16'hFFFF, sat_flags = 9'h1FF.
// - Backpressure: hold out_ready=0 for 5 cycles after out_valid, keep in_valid=1 with new operands.
//   - Expect: r_flat stable, in_ready = 0, out_valid held.
//   - Second job accepted on the cycle after the out_ready handshake.
// - Reset mid-operation: assert rst_n=0 at cycle 10 of COMPUTE for 2 cycles.
//   - Expect: immediately r_flat=0, busy=0, out_valid=0, in_ready=1.
//   - Expect: no out_valid for the aborted job; the next job computes correctly.
// - Parametric N=4, W=8: random A, B, 100 back-to-back jobs.
//   - Expect: match a reference model mod 2^8; latency 64 cycles each.

Source files
------------

// File: rtl/matmul_seq_mac_if.sv
// Handshake bundle for matmul_seq_mac.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : the multiplier (drives in_ready, results, status)
// Signals: in_valid/in_ready, a_flat/b_flat (N*N*W, element [i][j] at (i*N+j)*W),
//          out_valid/out_ready, r_flat (same packing), busy, sat_flags (bit i*N+j).
interface matmul_seq_mac_if #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [N*N*W-1:0] a_flat;
  logic [N*N*W-1:0] b_flat;
  logic             out_valid;
  logic             out_ready;
  logic [N*N*W-1:0] r_flat;
  logic             busy;
  logic [N*N-1:0]   sat_flags;

  modport master (
    output in_valid, a_flat, b_flat, out_ready,
    input  in_ready, out_valid, r_flat, busy, sat_flags
  );

  modport slave (
    input  in_valid, a_flat, b_flat, out_ready,
    output in_ready, out_valid, r_flat, busy, sat_flags
  );
endinterface

// File: rtl/matmul_seq_mac.sv
// Sequential N x N unsigned matrix multiplier, R = A x B, using a single shared MAC
// iterated over i, j, k (N^3 cycles per job).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - matmul_seq_mac_if.slave: in_valid/in_ready operand handshake (a_flat, b_flat),
//           out_valid/out_ready result handshake (r_flat), busy, sat_flags.
// Optional feature: define MATMUL_SATURATE_EN to clamp results to 2^W-1 and report clamped
// elements in sat_flags; otherwise results wrap modulo 2^W and sat_flags is tied to zero.
module matmul_seq_mac #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 16
) (
  input logic             clk,
  input logic             rst_n,
  matmul_seq_mac_if.slave bus
);

  // Wide enough that N products of two W-bit values never overflow.
  localparam int unsigned AccW = 2 * W + $clog2(N);
  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned MatW = N * N * W;
  localparam logic [IdxW-1:0] IdxMax = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e            state_q, state_d;
  logic [MatW-1:0]   a_q, b_q;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [IdxW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic              accept;
  logic              wr_en;

  logic [W-1:0]      a_arr [N][N];
  logic [W-1:0]      b_arr [N][N];
  logic [W-1:0]      r_q   [N][N];
  logic [W-1:0]      a_el, b_el;
  logic [2*W-1:0]    prod;
  logic [AccW-1:0]   sum;
  logic [W-1:0]      red;

  // Operand views and result packing.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      assign a_arr[gi][gj] = a_q[(gi*N+gj)*W +: W];
      assign b_arr[gi][gj] = b_q[(gi*N+gj)*W +: W];
      assign bus.r_flat[(gi*N+gj)*W +: W] = r_q[gi][gj];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q[gi][gj] <= '0;
        end else if (wr_en && i_q == IdxW'(gi) && j_q == IdxW'(gj)) begin
          r_q[gi][gj] <= red;
        end
      end
    end
  end

  // Shared MAC datapath.
  assign a_el = a_arr[i_q][k_q];
  assign b_el = b_arr[k_q][j_q];
  assign prod = (2*W)'(a_el) * (2*W)'(b_el);
  assign sum  = acc_q + AccW'(prod);

`ifdef MATMUL_SATURATE_EN
  logic           sat_hit;
  logic [N*N-1:0] sat_q;

  assign sat_hit = |sum[AccW-1:W];
  assign red     = sat_hit ? {W{1'b1}} : sum[W-1:0];

  for (genvar gs = 0; gs < N * N; gs++) begin : g_sat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sat_q[gs] <= 1'b0;
      end else if (accept) begin
        sat_q[gs] <= 1'b0;
      end else if (wr_en && (32'(i_q) * N + 32'(j_q)) == gs) begin
        sat_q[gs] <= sat_hit;
      end
    end
  end

  assign bus.sat_flags = sat_q;
`else
  assign red           = sum[W-1:0];
  assign bus.sat_flags = '0;
`endif

  // Next-state / iteration control.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    accept  = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = StCompute;
        end
      end
      StCompute: begin
        if (k_q != IdxMax) begin
          acc_d = sum;
          k_d   = k_q + 1'b1;
        end else begin
          // Last term of a dot product: commit element and step to the next (i, j).
          wr_en = 1'b1;
          acc_d = '0;
          k_d   = '0;
          if (j_q != IdxMax) begin
            j_d = j_q + 1'b1;
          end else begin
            j_d = '0;
            if (i_q != IdxMax) begin
              i_d = i_q + 1'b1;
            end else begin
              i_d     = '0;
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      if (accept) begin
        a_q <= bus.a_flat;
        b_q <= bus.b_flat;
      end
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q == StCompute);
  assign bus.out_valid = (state_q == StDone);

endmodule

// File: tb/tb_matmul_seq_mac.sv
module tb_matmul_seq_mac;
  localparam int unsigned N3 = 3;
  localparam int unsigned W3 = 16;
  localparam int unsigned N4 = 4;
  localparam int unsigned W4 = 8;

  typedef logic [N3*N3*W3-1:0] mat3_t;
  typedef logic [N4*N4*W4-1:0] mat4_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  matmul_seq_mac_if #(.N(N3), .W(W3)) bus3 ();
  matmul_seq_mac_if #(.N(N4), .W(W4)) bus4 ();

  matmul_seq_mac #(.N(N3), .W(W3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  matmul_seq_mac #(.N(N4), .W(W4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int checks   = 0;
  int failures = 0;

  mat3_t          exp3_q[$];
  logic [8:0]     sat3_q[$];
  mat4_t          exp4_q[$];

  // Reference models: plain triple loop with full-width sums.
  function automatic mat3_t model3(input mat3_t a, input mat3_t b, output logic [8:0] sat);
    mat3_t r;
    longint unsigned s;
    r   = '0;
    sat = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s += 64'(a[(i*3+k)*16 +: 16]) * 64'(b[(k*3+j)*16 +: 16]);
`ifdef MATMUL_SATURATE_EN
        if (s > 64'hFFFF) begin
          r[(i*3+j)*16 +: 16] = 16'hFFFF;
          sat[i*3+j] = 1'b1;
        end else begin
          r[(i*3+j)*16 +: 16] = s[15:0];
        end
`else
        r[(i*3+j)*16 +: 16] = s[15:0];
`endif
      end
    end
    return r;
  endfunction

  function automatic mat4_t model4(input mat4_t a, input mat4_t b);
    mat4_t r;
    longint unsigned s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += 64'(a[(i*4+k)*8 +: 8]) * 64'(b[(k*4+j)*8 +: 8]);
`ifdef MATMUL_SATURATE_EN
        r[(i*4+j)*8 +: 8] = (s > 64'hFF) ? 8'hFF : s[7:0];
`else
        r[(i*4+j)*8 +: 8] = s[7:0];
`endif
      end
    end
    return r;
  endfunction

  function automatic mat3_t fill3(input logic [15:0] v);
    mat3_t m;
    for (int e = 0; e < 9; e++) m[e*16 +: 16] = v;
    return m;
  endfunction

  function automatic mat3_t rand3();
    mat3_t m;
    for (int e = 0; e < 9; e++) m[e*16 +: 16] = 16'($urandom_range(0, 65535));
    return m;
  endfunction

  // Present operands until accepted; push the expected result at the accept edge.
  task automatic send3(input mat3_t a, input mat3_t b, output bit ok);
    logic [8:0] s;
    mat3_t      e;
    ok = 1'b0;
    bus3.a_flat   = a;
    bus3.b_flat   = b;
    bus3.in_valid = 1'b1;
    for (int c = 0; c < 400 && !ok; c++) begin
      if (bus3.in_ready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus3.in_valid = 1'b0;
    bus3.a_flat   = ~a;
    bus3.b_flat   = ~b;
    if (ok) begin
      e = model3(a, b, s);
      exp3_q.push_back(e);
      sat3_q.push_back(s);
    end
  endtask

  // Called one step after the accept edge; counts cycles to out_valid and busy samples.
  task automatic wait3(output int lat, output int busy_cnt, output bit ok);
    lat = 0; busy_cnt = 0; ok = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (bus3.busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      if (bus3.out_valid === 1'b1) begin
        lat = c;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic send4(input mat4_t a, input mat4_t b, output bit ok);
    ok = 1'b0;
    bus4.a_flat   = a;
    bus4.b_flat   = b;
    bus4.in_valid = 1'b1;
    for (int c = 0; c < 400 && !ok; c++) begin
      if (bus4.in_ready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus4.in_valid = 1'b0;
    bus4.a_flat   = ~a;
    if (ok) exp4_q.push_back(model4(a, b));
  endtask

  task automatic wait4(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (bus4.out_valid === 1'b1) begin
        lat = c;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus3.in_valid = 1'b0; bus3.out_ready = 1'b0; bus3.a_flat = '0; bus3.b_flat = '0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.a_flat = '0; bus4.b_flat = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus3.in_ready !== 1'b1 || bus3.out_valid !== 1'b0 || bus3.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               bus3.in_ready, bus3.out_valid, bus3.busy);
    end
    checks++;
    if (bus3.r_flat !== '0 || bus3.sat_flags !== 9'h0) begin
      failures++;
      $display("FAIL reset_data: r_flat=%h sat_flags=%h, required 0", bus3.r_flat,
               bus3.sat_flags);
    end
    checks++;
    if (bus4.in_ready !== 1'b1 || bus4.r_flat !== '0) begin
      failures++;
      $display("FAIL reset_n4: in_ready=%b r_flat=%h, required 1 and 0", bus4.in_ready,
               bus4.r_flat);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_latency();
    mat3_t a, b, r;
    logic [8:0] s;
    int lat, bc;
    bit ok;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        a[(i*3+j)*16 +: 16] = (i == j) ? 16'd1 : 16'd0;
        b[(i*3+j)*16 +: 16] = 16'(i*3 + j + 1);
      end
    bus3.out_ready = 1'b1;
    send3(a, b, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL latency_accept: in_ready never seen"); end
    wait3(lat, bc, ok);
    checks++;
    if (!ok || lat != 27) begin
      failures++;
      $display("FAIL latency_cycles: got %0d (ok=%b), required 27", lat, ok);
    end
    checks++;
    if (bc != 27) begin failures++; $display("FAIL latency_busy: got %0d, required 27", bc); end
    r = exp3_q.pop_front();
    s = sat3_q.pop_front();
    checks++;
    if (bus3.r_flat !== b || bus3.r_flat !== r) begin
      failures++;
      $display("FAIL latency_result: got %h, required %h", bus3.r_flat, b);
    end
    checks++;
    if (bus3.in_ready !== 1'b0 || bus3.busy !== 1'b0) begin
      failures++;
      $display("FAIL latency_done_flags: in_ready=%b busy=%b, required 0 0", bus3.in_ready,
               bus3.busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus3.out_valid !== 1'b0 || bus3.in_ready !== 1'b1 || bus3.r_flat !== b) begin
      failures++;
      $display("FAIL latency_idle: out_valid=%b in_ready=%b r=%h, required 0 1 %h",
               bus3.out_valid, bus3.in_ready, bus3.r_flat, b);
    end
    bus3.out_ready = 1'b0;
  endtask

  // Runs a job with out_ready held high, comparing result and flags to the scoreboard.
  task automatic test_pattern(input string name, input mat3_t a, input mat3_t b,
                              input mat3_t req_r, input logic [8:0] req_s);
    mat3_t r;
    logic [8:0] s;
    int lat, bc;
    bit ok;
    bus3.out_ready = 1'b1;
    send3(a, b, ok);
    wait3(lat, bc, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout: no out_valid", name);
    end else begin
      r = exp3_q.pop_front();
      s = sat3_q.pop_front();
      checks++;
      if (bus3.r_flat !== r || bus3.r_flat !== req_r) begin
        failures++;
        $display("FAIL %s_result: got %h, required %h", name, bus3.r_flat, req_r);
      end
      checks++;
      if (bus3.sat_flags !== s || bus3.sat_flags !== req_s) begin
        failures++;
        $display("FAIL %s_sat: got %h, required %h", name, bus3.sat_flags, req_s);
      end
    end
    @(posedge clk); #1;
    bus3.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    mat3_t a1, b1, a2, b2, held, r;
    logic [8:0] s;
    int lat, bc;
    bit ok;
    a1 = rand3(); b1 = rand3(); a2 = rand3(); b2 = rand3();
    bus3.out_ready = 1'b0;
    send3(a1, b1, ok);
    wait3(lat, bc, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_timeout: no out_valid"); end
    r = exp3_q.pop_front();
    s = sat3_q.pop_front();
    checks++;
    if (bus3.r_flat !== r) begin
      failures++;
      $display("FAIL bp_result1: got %h, required %h", bus3.r_flat, r);
    end
    held = bus3.r_flat;
    bus3.a_flat = a2; bus3.b_flat = b2; bus3.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus3.r_flat !== held || bus3.in_ready !== 1'b0 || bus3.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold%0d: r=%h in_ready=%b out_valid=%b, required %h 0 1", c,
                 bus3.r_flat, bus3.in_ready, bus3.out_valid, held);
      end
    end
    bus3.out_ready = 1'b1;
    @(posedge clk); #1;
    bus3.out_ready = 1'b0;
    checks++;
    if (bus3.in_ready !== 1'b1 || bus3.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", bus3.in_ready,
               bus3.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus3.busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_second_accept: busy=%b, required 1", bus3.busy);
    end
    r = model3(a2, b2, s);
    bus3.in_valid = 1'b0;
    bus3.a_flat = '0; bus3.b_flat = '0;
    wait3(lat, bc, ok);
    checks++;
    if (!ok || lat != 27 || bus3.r_flat !== r) begin
      failures++;
      $display("FAIL bp_result2: lat=%0d r=%h, required 27 %h", lat, bus3.r_flat, r);
    end
    bus3.out_ready = 1'b1;
    @(posedge clk); #1;
    bus3.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    mat3_t a, b;
    int seen, lat, bc;
    bit ok;
    a = rand3(); b = rand3();
    send3(a, b, ok);
    void'(exp3_q.pop_back());
    void'(sat3_q.pop_back());
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus3.r_flat !== '0 || bus3.busy !== 1'b0 || bus3.out_valid !== 1'b0 ||
        bus3.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_immediate: r=%h busy=%b out_valid=%b in_ready=%b",
               bus3.r_flat, bus3.busy, bus3.out_valid, bus3.in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus3.out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midreset_no_output: out_valid seen %0d cycles, required 0", seen);
    end
    test_pattern("midreset_next", a, b, model3(a, b, seen[8:0]), seen[8:0]);
  endtask

  task automatic test_back_to_back();
    mat4_t a, b, r;
    int lat, bad_lat, bad_res;
    bit ok;
    bad_lat = 0; bad_res = 0;
    bus4.out_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      for (int e = 0; e < 16; e++) begin
        a[e*8 +: 8] = 8'($urandom_range(0, 255));
        b[e*8 +: 8] = 8'($urandom_range(0, 255));
      end
      send4(a, b, ok);
      wait4(lat, ok);
      checks++;
      if (!ok || lat != 64) begin
        failures++;
        $display("FAIL b2b_latency job %0d: got %0d, required 64", n, lat);
        if (!ok) break;
      end
      r = exp4_q.pop_front();
      checks++;
      if (bus4.r_flat !== r) begin
        failures++;
        $display("FAIL b2b_result job %0d: got %h, required %h", n, bus4.r_flat, r);
      end
    end
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
  endtask

  initial begin
    logic [8:0] sat_none;
    mat3_t ov_req;
    logic [8:0] ov_sat;
    sat_none = 9'h0;
`ifdef MATMUL_SATURATE_EN
    ov_req = fill3(16'hFFFF);
    ov_sat = 9'h1FF;
`else
    ov_req = fill3(16'hFFFA);
    ov_sat = 9'h000;
`endif
    test_reset();
    test_latency();
    test_pattern("twos", fill3(16'd2), fill3(16'd2), fill3(16'd12), sat_none);
    test_pattern("overflow", fill3(16'hFFFF), fill3(16'h0002), ov_req, ov_sat);
    test_pattern("twos_after_ovf", fill3(16'd2), fill3(16'd2), fill3(16'd12), sat_none);
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
